// File: rtl/stream_arb_mux.sv
// N-input valid/ready arbiter feeding a single registered output slot.
// MODE 0 is round-robin from a rotating pointer; MODE 1 is fixed priority, with the lowest index winning.
module stream_arb_mux #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int MODE  = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N*WIDTH-1:0]       in_data_i,
  input  logic [N-1:0]             in_valid_i,
  output logic [N-1:0]             in_ready_o,
  output logic [WIDTH-1:0]         out_data_o,
  output logic [$clog2(N)-1:0]     out_sel_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);

  localparam int SEL_W = $clog2(N);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             space;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic             accept;

  assign space  = !out_valid_q || out_ready_i;
  assign accept = space && grant_valid;

  // The scan runs from the far end back toward the start, so the candidate closest to the start is written last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid_i[i]) begin
          grant_valid = 1'b1;
          grant       = SEL_W'(i);
        end
      end
    end else begin
      for (int j = N - 1; j >= 0; j--) begin
        int idx;
        idx = int'(ptr_q) + j;
        if (idx >= N) idx = idx - N;
        if (in_valid_i[idx]) begin
          grant_valid = 1'b1;
          grant       = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    in_ready_o = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_o[i] = accept && (grant == SEL_W'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_data_d  = in_data_i[int'(grant)*WIDTH +: WIDTH];
      out_sel_d   = grant;
      out_valid_d = 1'b1;
      if (MODE == 0) begin
        ptr_d = (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Scoreboard bench for stream_arb_mux. Three instances are driven from shared stimulus:
// round-robin N=4, fixed-priority N=4, and round-robin N=3.
module tb_stream_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN = 1'b0;
  logic [63:0] inData = '0;
  logic [3:0]  inValid = '0;
  logic        outReady = 1'b0;

  wire [3:0]  rdyRr, rdyFp;
  wire [2:0]  rdyN3;
  wire [15:0] dataRr, dataFp, dataN3;
  wire [1:0]  selRr, selFp, selN3;
  wire        validRr, validFp, validN3;

  stream_arb_mux #(.WIDTH(16), .N(4), .MODE(0)) dutRr (
    .clk_i(clk), .rst_ni(rstN), .in_data_i(inData), .in_valid_i(inValid),
    .in_ready_o(rdyRr), .out_data_o(dataRr), .out_sel_o(selRr),
    .out_valid_o(validRr), .out_ready_i(outReady));

  stream_arb_mux #(.WIDTH(16), .N(4), .MODE(1)) dutFp (
    .clk_i(clk), .rst_ni(rstN), .in_data_i(inData), .in_valid_i(inValid),
    .in_ready_o(rdyFp), .out_data_o(dataFp), .out_sel_o(selFp),
    .out_valid_o(validFp), .out_ready_i(outReady));

  stream_arb_mux #(.WIDTH(16), .N(3), .MODE(0)) dutN3 (
    .clk_i(clk), .rst_ni(rstN), .in_data_i(inData[47:0]), .in_valid_i(inValid[2:0]),
    .in_ready_o(rdyN3), .out_data_o(dataN3), .out_sel_o(selN3),
    .out_valid_o(validN3), .out_ready_i(outReady));

  logic [3:0]  dutReady [3];
  logic        dutValid [3];
  logic [17:0] dutWord  [3];

  always_comb begin
    dutReady[0] = rdyRr;
    dutReady[1] = rdyFp;
    dutReady[2] = {1'b0, rdyN3};
    dutValid[0] = validRr;
    dutValid[1] = validFp;
    dutValid[2] = validN3;
    dutWord[0]  = {selRr, dataRr};
    dutWord[1]  = {selFp, dataFp};
    dutWord[2]  = {selN3, dataN3};
  end

  int    nCh    [3] = '{4, 4, 3};
  int    modeOf [3] = '{0, 1, 0};
  string nameOf [3] = '{"rr", "fp", "n3"};

  int          ptrM [3];
  logic        ovM  [3];
  logic [17:0] expQ [3][$];

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] SEQ_DATA = {16'h1003, 16'h1002, 16'h1001, 16'h1000};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int modelGrant(input int n, input int mode, input logic [3:0] v, input int ptr);
    for (int j = 0; j < n; j++) begin
      int idx;
      idx = (mode == 1) ? j : (ptr + j) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Inputs have settled and the next clock edge has not arrived yet. Compare the DUTs against the model, then advance the model through that edge.
  task automatic evalModel(input bit inReset);
    for (int k = 0; k < 3; k++) begin
      logic       space;
      int         g;
      logic [3:0] expReady;
      logic [1:0] gs;
      space    = !ovM[k] || outReady;
      g        = modelGrant(nCh[k], modeOf[k], inValid, ptrM[k]);
      expReady = (space && g >= 0) ? 4'(1 << g) : 4'b0000;
      checkOutput({nameOf[k], "_ready"}, 32'(dutReady[k]), 32'(expReady));
      checkOutput({nameOf[k], "_valid"}, 32'(dutValid[k]), 32'(ovM[k]));
      if (!inReset) begin
        if (ovM[k] && expQ[k].size() > 0) begin
          checkOutput({nameOf[k], "_word"}, 32'(dutWord[k]), 32'(expQ[k][0]));
          if (outReady) void'(expQ[k].pop_front());
        end
        if (space && g >= 0) begin
          gs = 2'(g);
          expQ[k].push_back({gs, inData[g*16 +: 16]});
          ovM[k] = 1'b1;
          if (modeOf[k] == 0) ptrM[k] = (g == nCh[k] - 1) ? 0 : g + 1;
        end else if (outReady) begin
          ovM[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [63:0] d, input logic r);
    @(negedge clk);
    inValid  = v;
    inData   = d;
    outReady = r;
    #1;
    evalModel(1'b0);
  endtask

  // Reset is asserted partway through the low phase. Nothing changes on an edge here, so the checks only pass if the reset acts asynchronously.
  task automatic applyReset();
    @(negedge clk);
    #2;
    rstN = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      inValid  = 4'($urandom);
      inData   = {$urandom, $urandom};
      outReady = 1'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        ptrM[k] = 0;
        ovM[k]  = 1'b0;
        expQ[k].delete();
        checkOutput({nameOf[k], "_rstword"}, 32'(dutWord[k]), 32'h0);
      end
      evalModel(1'b1);
    end
    @(negedge clk);
    inValid  = 4'b0000;
    outReady = 1'b1;
    rstN     = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      ptrM[k] = 0;
      ovM[k]  = 1'b0;
    end

    $display("[TB] reset values and first accept");
    applyReset();
    applyStimulus(4'b0100, 64'h0000_00AA_0000_0000, 1'b1);
    applyStimulus(4'b0000, 64'h0, 1'b1);

    $display("[TB] round-robin fairness");
    for (int i = 0; i < 10; i++) applyStimulus(4'b1111, SEQ_DATA, 1'b1);
    applyStimulus(4'b0000, SEQ_DATA, 1'b1);

    $display("[TB] backpressure");
    applyReset();
    applyStimulus(4'b1111, SEQ_DATA, 1'b1);
    applyStimulus(4'b1111, SEQ_DATA, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, SEQ_DATA, 1'b0);
    applyStimulus(4'b1111, SEQ_DATA, 1'b1);
    applyStimulus(4'b0000, SEQ_DATA, 1'b1);

    $display("[TB] fixed priority");
    applyStimulus(4'b1010, SEQ_DATA, 1'b1);
    applyStimulus(4'b1010, SEQ_DATA, 1'b1);
    applyStimulus(4'b1011, SEQ_DATA, 1'b1);
    applyStimulus(4'b1000, SEQ_DATA, 1'b1);
    applyStimulus(4'b0000, SEQ_DATA, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] reset mid-operation");
    applyStimulus(4'b1111, SEQ_DATA, 1'b0);
    applyStimulus(4'b1111, SEQ_DATA, 1'b0);
    applyReset();
    applyStimulus(4'b0110, SEQ_DATA, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b1111, SEQ_DATA, 1'b1);
    applyStimulus(4'b0000, SEQ_DATA, 1'b1);
    applyStimulus(4'b0000, SEQ_DATA, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
